// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle adder: sums two WIDTH-bit operands plus carry-in, DIGIT bits
//   per clock, with the inter-digit carry held in a register.
//   Valid/ready handshake on the operand side and on the result side.
//
// Parameters
//   WIDTH      operand/sum width (must be a multiple of DIGIT)
//   DIGIT      bits added per clock (1 <= DIGIT <= WIDTH)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   operand set a/b/cin valid
//   in_ready   block can accept operands (IDLE)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in
//   out_valid  sum/cout valid (DONE)
//   out_ready  consumer accepts the result
//   sum        registered (a+b+cin) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow flag, only when ADDER_OVF_FLAG_EN is defined
//
// Build option
//   ADDER_OVF_FLAG_EN  adds the ovf output and its logic.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands; in_ready=1, last result still on sum
// RUN   | adding one digit per edge, LSB digit first
// DONE  | result valid, held until out_ready
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] s_dig;
  logic             c_dig;
  logic             last;
`ifdef ADDER_OVF_FLAG_EN
  logic             msb_cin;
`endif

  // One digit slice of the add, DIGIT+1 bits wide so the carry falls out on top.
  always_comb begin
    a_dig          = a_q[int'(cnt)*DIGIT +: DIGIT];
    b_dig          = b_q[int'(cnt)*DIGIT +: DIGIT];
    {c_dig, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    last           = (cnt == CW'(NDIG - 1));
`ifdef ADDER_OVF_FLAG_EN
    // Carry into the top bit recovered from its half-sum: s = a ^ b ^ c_in.
    msb_cin        = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef ADDER_OVF_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Operands are sampled only here, so X on a/b while idle never reaches the outputs.
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[int'(cnt)*DIGIT +: DIGIT] <= s_dig;
          carry <= c_dig;
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout      <= c_dig;
`ifdef ADDER_OVF_FLAG_EN
            ovf       <= msb_cin ^ c_dig;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Return to IDLE only; a new accept cannot happen in this same cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
